// File: rtl/fp_frame_scale_if.sv
// Complex float32 sample stream into and out of the frame scaler.
// Valid/ready handshake on both sides; out_last marks the frame's final sample.
interface fp_frame_scale_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_re;
  logic [31:0] in_img;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_re;
  logic [31:0] out_img;
  logic        out_last;

  modport master (
    output in_valid, in_re, in_img, out_ready,
    input  in_ready, out_valid, out_re, out_img, out_last
  );

  modport slave (
    input  in_valid, in_re, in_img, out_ready,
    output in_ready, out_valid, out_re, out_img, out_last
  );
endinterface

// File: rtl/fp_frame_scale_ctrl.sv
// Per-frame 2^-shift scaling of complex float32 samples by exponent subtraction,
// with frame sequencing, a single registered output stage and underflow counting.
module fp_frame_scale_ctrl #(
  parameter int FRAME_LEN = 125,
  parameter int CNT_W     = 7,
  parameter int SHIFT_W   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [SHIFT_W-1:0] cfg_shift,
  fp_frame_scale_if.slave    bus,
  output logic               busy,
  output logic               done,
  output logic [15:0]        uflow_cnt
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [SHIFT_W-1:0] shift;
  logic               vld_p1;
  logic               last_p1;
  logic [31:0]        re_p1;
  logic [31:0]        img_p1;
  logic               accept;
  logic               xfer;
  logic               take;
  logic               last_in;
  logic [1:0]         uflow_inc;

  // Inf/NaN pass; zero, denormal and exponents that would reach <= 0 flush to signed zero.
  function automatic logic [31:0] scale_comp(input logic [31:0] x, input logic [SHIFT_W-1:0] s);
    logic [7:0] e;
    logic [7:0] sx;
    e  = x[30:23];
    sx = 8'(s);
    if (e == 8'hFF)
      scale_comp = x;
    else if (e <= sx)
      scale_comp = {x[31], 31'd0};
    else
      scale_comp = {x[31], e - sx, x[22:0]};
  endfunction

  function automatic logic is_uflow(input logic [31:0] x, input logic [SHIFT_W-1:0] s);
    logic [7:0] e;
    e = x[30:23];
    is_uflow = (e != 8'h00) && (e != 8'hFF) && (e <= 8'(s));
  endfunction

  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [1:0] inc);
    logic [16:0] sum;
    sum     = {1'b0, a} + {15'd0, inc};
    sat_add = sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

  // A start coinciding with the done pulse is deliberately refused.
  assign accept       = (state == IDLE) && start && !done;
  assign last_in      = (cnt == CNT_W'(FRAME_LEN - 1));
  assign bus.in_ready = (state == RUN) && (!vld_p1 || bus.out_ready);
  assign xfer         = bus.in_valid && bus.in_ready;
  assign take         = vld_p1 && bus.out_ready;
  assign uflow_inc    = {1'b0, is_uflow(bus.in_re, shift)} + {1'b0, is_uflow(bus.in_img, shift)};
  assign busy         = (state != IDLE);

  assign bus.out_valid = vld_p1;
  assign bus.out_re    = re_p1;
  assign bus.out_img   = img_p1;
  assign bus.out_last  = last_p1;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (xfer && last_in) state_nxt = DRAIN;
      DRAIN:   if (take && last_p1) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      shift     <= '0;
      uflow_cnt <= '0;
      done      <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= (state == DRAIN) && take && last_p1;
      if (accept) begin
        cnt       <= '0;
        shift     <= cfg_shift;
        uflow_cnt <= '0;
      end else if (xfer) begin
        cnt       <= cnt + 1'b1;
        uflow_cnt <= sat_add(uflow_cnt, uflow_inc);
      end
    end
  end

  // Stage p1: registered scaled sample; holds while downstream stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
      re_p1   <= '0;
      img_p1  <= '0;
    end else if (xfer) begin
      vld_p1  <= 1'b1;
      last_p1 <= last_in;
      re_p1   <= scale_comp(bus.in_re, shift);
      img_p1  <= scale_comp(bus.in_img, shift);
    end else if (take) begin
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fp_frame_scale_ctrl.sv
// Randomised bench for fp_frame_scale_ctrl: a transaction-level model (expected
// output queue, frame counter, underflow tally) is compared every cycle.
module tb_fp_frame_scale_ctrl;
  localparam int FRAME_LEN = 125;
  localparam int BUDGET    = 4000;

  typedef struct packed {
    logic [31:0] re;
    logic [31:0] img;
    logic        last;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [3:0]  cfg_shift;
  logic        busy;
  logic        done;
  logic [15:0] uflow_cnt;

  fp_frame_scale_if bus ();

  fp_frame_scale_ctrl #(.FRAME_LEN(FRAME_LEN), .CNT_W(7), .SHIFT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_shift(cfg_shift),
    .bus(bus), .busy(busy), .done(done), .uflow_cnt(uflow_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   total = 0;
  int   bad   = 0;
  exp_t q[$];
  bit   m_busy, m_done;
  int   m_cnt, m_uflow, m_shift;

  logic [31:0] lit_re  [3] = '{32'h3F800000, 32'h02000000, 32'h7FC00000};
  logic [31:0] lit_img [3] = '{32'hC0000000, 32'h82800000, 32'h80000000};
  logic [31:0] lit_ore [3] = '{32'h3D800000, 32'h00000000, 32'h7FC00000};
  logic [31:0] lit_oimg[3] = '{32'hBE000000, 32'h80800000, 32'h80000000};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s got=%h want=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_scale(input logic [31:0] x, input int s);
    int e;
    e = int'(x[30:23]);
    if (e == 255) return x;
    if (e - s <= 0) return {x[31], 31'd0};
    return {x[31], 8'(e - s), x[22:0]};
  endfunction

  function automatic int ref_uflow(input logic [31:0] x, input int s);
    int e;
    e = int'(x[30:23]);
    return (e != 0 && e != 255 && e - s <= 0) ? 1 : 0;
  endfunction

  function automatic logic [31:0] rnd_f();
    logic [31:0] m;
    logic [7:0]  e;
    int          sel;
    m   = $urandom;
    sel = int'($urandom_range(0, 7));
    case (sel)
      0:       e = 8'h00;
      1:       e = 8'hFF;
      2, 3:    e = 8'($urandom_range(1, 20));
      default: e = 8'($urandom_range(0, 255));
    endcase
    return {m[31], e, m[22:0]};
  endfunction

  task automatic reset_checks(input string tag);
    check({tag, "_busy"},      32'(busy), 32'd0);
    check({tag, "_done"},      32'(done), 32'd0);
    check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_out_re"},    bus.out_re, 32'd0);
    check({tag, "_out_img"},   bus.out_img, 32'd0);
    check({tag, "_out_last"},  32'(bus.out_last), 32'd0);
    check({tag, "_uflow"},     32'(uflow_cnt), 32'd0);
    check({tag, "_in_ready"},  32'(bus.in_ready), 32'd0);
  endtask

  task automatic monitor();
    bit acc, new_done, exp_rdy;
    int sum;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        q.delete();
        m_busy = 0; m_done = 0; m_cnt = 0; m_uflow = 0; m_shift = 0;
        continue;
      end
      exp_rdy = m_busy && (m_cnt < FRAME_LEN) && (q.size() == 0 || bus.out_ready);
      check("busy",      32'(busy), 32'(m_busy));
      check("done",      32'(done), 32'(m_done));
      check("uflow_cnt", 32'(uflow_cnt), 32'(m_uflow));
      check("out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
      check("in_ready",  32'(bus.in_ready), 32'(exp_rdy));
      if (q.size() != 0) begin
        check("out_re",   bus.out_re, q[0].re);
        check("out_img",  bus.out_img, q[0].img);
        check("out_last", 32'(bus.out_last), 32'(q[0].last));
      end
      acc      = start && !m_busy && !m_done;
      new_done = 0;
      if (q.size() != 0 && bus.out_ready) begin
        if (q[0].last) new_done = 1;
        void'(q.pop_front());
      end
      if (exp_rdy && bus.in_valid) begin
        q.push_back('{re: ref_scale(bus.in_re, m_shift), img: ref_scale(bus.in_img, m_shift),
                      last: (m_cnt == FRAME_LEN - 1)});
        sum     = m_uflow + ref_uflow(bus.in_re, m_shift) + ref_uflow(bus.in_img, m_shift);
        m_uflow = (sum > 65535) ? 65535 : sum;
        m_cnt   = m_cnt + 1;
      end
      if (new_done) m_busy = 0;
      if (acc) begin
        m_busy  = 1;
        m_cnt   = 0;
        m_uflow = 0;
        m_shift = int'(cfg_shift);
      end
      m_done = new_done;
    end
  endtask

  task automatic do_start(input int sh);
    @(posedge clk); #1;
    start     = 1'b1;
    cfg_shift = 4'(sh);
    @(posedge clk); #1;
    start     = 1'b0;
  endtask

  task automatic run_frame(input int sh, input int vprob, input int rprob, input bit directed,
                           input int mid_start_at, input int rst_at, input bit start_on_done);
    int cyc;
    bit mid_fired;
    cyc       = 0;
    mid_fired = 0;
    do_start(sh);
    forever begin
      @(posedge clk); #1;
      start = 1'b0;
      if (done) break;
      cyc = cyc + 1;
      if (cyc > BUDGET) begin
        total = total + 1;
        bad   = bad + 1;
        $display("FAIL frame_timeout cycles=%0d limit=%0d", cyc, BUDGET);
        break;
      end
      if (directed && m_cnt >= 1 && m_cnt <= 3) begin
        check("lit_out_re",  bus.out_re,  lit_ore[m_cnt-1]);
        check("lit_out_img", bus.out_img, lit_oimg[m_cnt-1]);
        if (m_cnt == 3) check("lit_uflow_after_table", 32'(uflow_cnt), 32'd1);
      end
      if (rst_at >= 0 && m_cnt == rst_at) begin
        #2;
        rst_n = 1'b0;
        #1;
        reset_checks("midrst");
        @(posedge clk); #1;
        rst_n        = 1'b1;
        bus.in_valid = 1'b0;
        return;
      end
      if (mid_start_at >= 0 && m_cnt == mid_start_at && !mid_fired) begin
        start     = 1'b1;
        cfg_shift = 4'd1;
        mid_fired = 1;
      end
      bus.in_valid  = ($urandom_range(0, 99) < vprob);
      bus.out_ready = ($urandom_range(0, 99) < rprob);
      if (directed && m_cnt < 3) begin
        bus.in_re  = lit_re[m_cnt];
        bus.in_img = lit_img[m_cnt];
      end else begin
        bus.in_re  = rnd_f();
        bus.in_img = rnd_f();
      end
    end
    bus.in_valid = 1'b0;
    if (start_on_done) begin
      start     = 1'b1;
      cfg_shift = 4'd9;
      @(posedge clk); #1;
      start = 1'b0;
      check("start_on_done_ignored", 32'(busy), 32'd0);
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    start         = 1'b0;
    cfg_shift     = '0;
    bus.in_valid  = 1'b0;
    bus.in_re     = '0;
    bus.in_img    = '0;
    bus.out_ready = 1'b0;
    fork
      monitor();
    join_none
    #1;
    reset_checks("por");

    check("pin_one",      ref_scale(32'h3F800000, 4), 32'h3D800000);
    check("pin_neg_two",  ref_scale(32'hC0000000, 4), 32'hBE000000);
    check("pin_uflow_e4", ref_scale(32'h02000000, 4), 32'h00000000);
    check("pin_e5",       ref_scale(32'h82800000, 4), 32'h80800000);
    check("pin_nan",      ref_scale(32'h7FC00000, 4), 32'h7FC00000);
    check("pin_negzero",  ref_scale(32'h80000000, 4), 32'h80000000);
    check("pin_shift0",   ref_scale(32'h3F800000, 0), 32'h3F800000);
    check("pin_uf_cnt",   32'(ref_uflow(32'h02000000, 4)), 32'd1);
    check("pin_uf_zero",  32'(ref_uflow(32'h80000000, 4)), 32'd0);

    #20;
    @(posedge clk); #1;
    rst_n = 1'b1;

    run_frame(4, 100, 100, 1'b1, -1, -1, 1'b1);
    run_frame(4, 70, 50, 1'b0, 50, -1, 1'b0);
    run_frame(0, 80, 60, 1'b0, -1, -1, 1'b1);
    run_frame(7, 90, 70, 1'b0, -1, 60, 1'b0);
    run_frame(15, 100, 40, 1'b0, -1, -1, 1'b0);
    run_frame(3, 50, 100, 1'b0, -1, -1, 1'b0);

    repeat (5) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
